// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write-port arbiter slice.
//   DATA_W    register width
//   IDX_W     register index width
//   NUM_REGS  number of architectural registers (2**IDX_W)
//   ZERO_REG  index of the hard-wired zero register (never written)
//   rf_wreq_t writeback request payload {index, data}
//   rf_prio_e round-robin pointer encoding
//   idx_onehot() index to one-hot register mask helper
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int IDX_W    = 5;
    localparam int NUM_REGS = 32;

    localparam logic [IDX_W-1:0] ZERO_REG = {IDX_W{1'b0}};

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } rf_wreq_t;

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } rf_prio_e;

    // One-hot mask for a register index.
    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh      = {NUM_REGS{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Pending-destination scoreboard and read-hazard stall generation.
//   clock, clear_n     clock and synchronous active-low reset
//   set_en_i/set_idx_i reservation from decode (index 0 ignored)
//   clr_en_i/clr_idx_i write issued to the register file (index 0 ignored)
//   read_idx1_i/2_i    decode source registers
//   fwd1_hit_i/2_hit_i source is satisfied by the write currently on the port
//   pending_o          pending vector
//   stall_o            a source register is still pending
// -----------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                clock,
    input  logic                clear_n,
    input  logic                set_en_i,
    input  logic [IDX_W-1:0]    set_idx_i,
    input  logic                clr_en_i,
    input  logic [IDX_W-1:0]    clr_idx_i,
    input  logic [IDX_W-1:0]    read_idx1_i,
    input  logic [IDX_W-1:0]    read_idx2_i,
    input  logic                fwd1_hit_i,
    input  logic                fwd2_hit_i,
    output logic [NUM_REGS-1:0] pending_o,
    output logic                stall_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic                src1_hit_s;
    logic                src2_hit_s;

    // Next pending vector: clear first, then set, so a same-edge reserve wins.
    always_comb begin
        set_mask_s = {NUM_REGS{1'b0}};
        clr_mask_s = {NUM_REGS{1'b0}};
        if (set_en_i && (set_idx_i != ZERO_REG)) begin
            set_mask_s = idx_onehot(set_idx_i);
        end else begin
            set_mask_s = {NUM_REGS{1'b0}};
        end
        if (clr_en_i && (clr_idx_i != ZERO_REG)) begin
            clr_mask_s = idx_onehot(clr_idx_i);
        end else begin
            clr_mask_s = {NUM_REGS{1'b0}};
        end
        pending_d = (pending_q & ~clr_mask_s) | set_mask_s;
    end

    // Pending vector register.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            pending_q <= {NUM_REGS{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    // Hazard compare; register 0 never stalls, forwarded sources never stall.
    always_comb begin
        src1_hit_s = 1'b0;
        src2_hit_s = 1'b0;
        if (read_idx1_i != ZERO_REG) begin
            src1_hit_s = pending_q[read_idx1_i] & ~fwd1_hit_i;
        end else begin
            src1_hit_s = 1'b0;
        end
        if (read_idx2_i != ZERO_REG) begin
            src2_hit_s = pending_q[read_idx2_i] & ~fwd2_hit_i;
        end else begin
            src2_hit_s = 1'b0;
        end
    end

    assign stall_o   = src1_hit_s | src2_hit_s;
    assign pending_o = pending_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the single register-file write port between ALU writeback (req0)
// and load writeback (req1). Each requester owns a 1-entry slot; occupied
// slots are arbitrated round-robin and the winner is registered onto the
// write port. The register file samples on the falling edge.
//   clock, clear_n                  clock, synchronous active-low reset
//   req0_valid/ready/index/data     ALU writeback handshake
//   req1_valid/ready/index/data     load writeback handshake
//   reserve, reserve_index          destination reservation from decode
//   read_index1, read_index2        decode source registers
//   stall                           read hazard toward decode
//   pending                         scoreboard vector
//   write, write_index, write_data  register file write port (flopped)
// Optional build macro RF_FWD_EN adds fwd1_valid/fwd1_data/fwd2_valid/
// fwd2_data and lets a forwarded source suppress its stall.
// -----------------------------------------------------------------------------
module rf_write_arbiter
    import rf_pkg::*;
(
    input  logic                clock,
    input  logic                clear_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [IDX_W-1:0]    req0_index,
    input  logic [DATA_W-1:0]   req0_data,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [IDX_W-1:0]    req1_index,
    input  logic [DATA_W-1:0]   req1_data,
    input  logic                reserve,
    input  logic [IDX_W-1:0]    reserve_index,
    input  logic [IDX_W-1:0]    read_index1,
    input  logic [IDX_W-1:0]    read_index2,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    output logic                write,
    output logic [IDX_W-1:0]    write_index,
    output logic [DATA_W-1:0]   write_data
`ifdef RF_FWD_EN
    ,
    output logic                fwd1_valid,
    output logic [DATA_W-1:0]   fwd1_data,
    output logic                fwd2_valid,
    output logic [DATA_W-1:0]   fwd2_data
`endif
);

    rf_wreq_t          slot0_q, slot0_d;
    rf_wreq_t          slot1_q, slot1_d;
    logic              slot0_vld_q, slot0_vld_d;
    logic              slot1_vld_q, slot1_vld_d;
    rf_prio_e          ptr_q, ptr_d;
    logic              write_q;
    logic [IDX_W-1:0]  write_index_q;
    logic [DATA_W-1:0] write_data_q;

    logic              accept0_s;
    logic              accept1_s;
    logic              grant0_s;
    logic              grant1_s;
    logic              grant_any_s;
    logic              issue_s;
    rf_wreq_t          win_s;
    logic              fwd1_hit_s;
    logic              fwd2_hit_s;

    // Ready reflects the registered slot state only, so a slot freed this
    // edge is offered again next cycle (no pass-through path).
    assign req0_ready = ~slot0_vld_q;
    assign req1_ready = ~slot1_vld_q;
    assign accept0_s  = req0_valid & ~slot0_vld_q;
    assign accept1_s  = req1_valid & ~slot1_vld_q;

    // Round-robin arbitration; the pointer only moves on real contention.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        ptr_d    = ptr_q;
        if (slot0_vld_q && slot1_vld_q) begin
            case (ptr_q)
                PRIO_REQ0: begin
                    grant0_s = 1'b1;
                    ptr_d    = PRIO_REQ1;
                end
                PRIO_REQ1: begin
                    grant1_s = 1'b1;
                    ptr_d    = PRIO_REQ0;
                end
                default: begin
                    grant0_s = 1'b1;
                    ptr_d    = PRIO_REQ1;
                end
            endcase
        end else if (slot0_vld_q) begin
            grant0_s = 1'b1;
        end else if (slot1_vld_q) begin
            grant1_s = 1'b1;
        end else begin
            ptr_d = ptr_q;
        end
        grant_any_s = grant0_s | grant1_s;
        if (grant1_s) begin
            win_s = slot1_q;
        end else begin
            win_s = slot0_q;
        end
        // A zero-index winner is consumed but never raises write.
        issue_s = grant_any_s & (win_s.index != ZERO_REG);
    end

    // Slot next state: a granted slot empties; an empty slot may accept.
    always_comb begin
        slot0_vld_d = slot0_vld_q;
        slot0_d     = slot0_q;
        slot1_vld_d = slot1_vld_q;
        slot1_d     = slot1_q;
        if (grant0_s) begin
            slot0_vld_d = 1'b0;
        end else if (accept0_s) begin
            slot0_vld_d   = 1'b1;
            slot0_d.index = req0_index;
            slot0_d.data  = req0_data;
        end else begin
            slot0_vld_d = slot0_vld_q;
        end
        if (grant1_s) begin
            slot1_vld_d = 1'b0;
        end else if (accept1_s) begin
            slot1_vld_d   = 1'b1;
            slot1_d.index = req1_index;
            slot1_d.data  = req1_data;
        end else begin
            slot1_vld_d = slot1_vld_q;
        end
    end

    // Slot, pointer and write-port registers.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            slot0_vld_q   <= 1'b0;
            slot1_vld_q   <= 1'b0;
            slot0_q       <= '{index: {IDX_W{1'b0}}, data: {DATA_W{1'b0}}};
            slot1_q       <= '{index: {IDX_W{1'b0}}, data: {DATA_W{1'b0}}};
            ptr_q         <= PRIO_REQ0;
            write_q       <= 1'b0;
            write_index_q <= {IDX_W{1'b0}};
            write_data_q  <= {DATA_W{1'b0}};
        end else begin
            slot0_vld_q <= slot0_vld_d;
            slot1_vld_q <= slot1_vld_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            ptr_q       <= ptr_d;
            write_q     <= issue_s;
            // Index/data hold their last value while the port is idle.
            if (grant_any_s) begin
                write_index_q <= win_s.index;
                write_data_q  <= win_s.data;
            end else begin
                write_index_q <= write_index_q;
                write_data_q  <= write_data_q;
            end
        end
    end

    assign write       = write_q;
    assign write_index = write_index_q;
    assign write_data  = write_data_q;

`ifdef RF_FWD_EN
    // The write on the port this cycle satisfies a matching source read.
    assign fwd1_hit_s = write_q & (write_index_q == read_index1) & (read_index1 != ZERO_REG);
    assign fwd2_hit_s = write_q & (write_index_q == read_index2) & (read_index2 != ZERO_REG);
    assign fwd1_valid = fwd1_hit_s;
    assign fwd2_valid = fwd2_hit_s;
    assign fwd1_data  = write_data_q;
    assign fwd2_data  = write_data_q;
`else
    assign fwd1_hit_s = 1'b0;
    assign fwd2_hit_s = 1'b0;
`endif

    rf_scoreboard u_scoreboard (
        .clock       (clock),
        .clear_n     (clear_n),
        .set_en_i    (reserve),
        .set_idx_i   (reserve_index),
        .clr_en_i    (issue_s),
        .clr_idx_i   (win_s.index),
        .read_idx1_i (read_index1),
        .read_idx2_i (read_index2),
        .fwd1_hit_i  (fwd1_hit_s),
        .fwd2_hit_i  (fwd2_hit_s),
        .pending_o   (pending),
        .stall_o     (stall)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
// Directed self-checking bench for rf_write_arbiter. Inputs change 2 time
// units after a rising edge; outputs are sampled before the next edge.
// Honors RF_FWD_EN for the forwarding ports.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_index, req1_index;
    logic [31:0] req0_data, req1_data;
    logic        reserve;
    logic [4:0]  reserve_index;
    logic [4:0]  read_index1, read_index2;
    logic        stall;
    logic [31:0] pending;
    logic        write;
    logic [4:0]  write_index;
    logic [31:0] write_data;
`ifdef RF_FWD_EN
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    int checks   = 0;
    int failures = 0;
    int acc0;
    int acc1;
    logic [31:0] exp_idx;
    logic [31:0] exp_data;

    always #5 clock = ~clock;

    rf_write_arbiter dut (
        .clock         (clock),
        .clear_n       (clear_n),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_index    (req0_index),
        .req0_data     (req0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_index    (req1_index),
        .req1_data     (req1_data),
        .reserve       (reserve),
        .reserve_index (reserve_index),
        .read_index1   (read_index1),
        .read_index2   (read_index2),
        .stall         (stall),
        .pending       (pending),
        .write         (write),
        .write_index   (write_index),
        .write_data    (write_data)
`ifdef RF_FWD_EN
        ,
        .fwd1_valid    (fwd1_valid),
        .fwd1_data     (fwd1_data),
        .fwd2_valid    (fwd2_valid),
        .fwd2_data     (fwd2_data)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decode must never reserve an index that is already pending.
    task automatic reserve_rule(input logic [4:0] idx);
        checks++;
        assert (pending[idx] === 1'b0) else begin
            failures++;
            $error("FAIL reserve_rule idx=%0d observed_pending=%b expected=0", idx, pending[idx]);
        end
    endtask

    initial begin
        clear_n       = 1'b0;
        req0_valid    = 1'b1;
        req0_index    = 5'd1;
        req0_data     = 32'h0000_0011;
        req1_valid    = 1'b1;
        req1_index    = 5'd2;
        req1_data     = 32'h0000_0022;
        reserve       = 1'b0;
        reserve_index = 5'd0;
        read_index1   = 5'd0;
        read_index2   = 5'd0;

        // ---- reset with both requesters valid ----
        tick();
        tick();
        chk("rst_ready0", {31'd0, req0_ready}, 32'd1);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd1);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_windex", {27'd0, write_index}, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        clear_n    = 1'b1;
        tick();
        chk("post_rst_write_a", {31'd0, write}, 32'd0);
        tick();
        chk("post_rst_write_b", {31'd0, write}, 32'd0);

        // ---- single write to r5 ----
        read_index1   = 5'd5;
        reserve_rule(5'd5);
        reserve       = 1'b1;
        reserve_index = 5'd5;
        tick();
        reserve = 1'b0;
        #1;
        chk("sw_pend_set", pending, 32'h0000_0020);
        chk("sw_stall_set", {31'd0, stall}, 32'd1);
        req0_valid = 1'b1;
        req0_index = 5'd5;
        req0_data  = 32'hDEAD_BEEF;
        tick();
        req0_valid = 1'b0;
        #1;
        chk("sw_ready0_busy", {31'd0, req0_ready}, 32'd0);
        chk("sw_write_lat", {31'd0, write}, 32'd0);
        chk("sw_pend_hold", pending, 32'h0000_0020);
        chk("sw_stall_hold", {31'd0, stall}, 32'd1);
        tick();
        chk("sw_write", {31'd0, write}, 32'd1);
        chk("sw_windex", {27'd0, write_index}, 32'd5);
        chk("sw_wdata", write_data, 32'hDEAD_BEEF);
        chk("sw_pend_clr", pending, 32'd0);
        chk("sw_stall_clr", {31'd0, stall}, 32'd0);
        chk("sw_ready0_back", {31'd0, req0_ready}, 32'd1);
        tick();
        chk("sw_idle", {31'd0, write}, 32'd0);
        read_index1 = 5'd0;

        // ---- contention: r3 from req0, r4 from req1, 4 accepts each ----
        acc0       = 0;
        acc1       = 0;
        req0_index = 5'd3;
        req0_data  = 32'hA0A0_0003;
        req1_index = 5'd4;
        req1_data  = 32'hB0B0_0004;
        for (int k = 1; k <= 9; k++) begin
            req0_valid = (acc0 < 4);
            req1_valid = (acc1 < 4);
            #1;
            if (req0_valid && req0_ready) acc0++;
            if (req1_valid && req1_ready) acc1++;
            tick();
            if (k >= 2) begin
                exp_idx  = ((k % 2) == 0) ? 32'd3 : 32'd4;
                exp_data = ((k % 2) == 0) ? 32'hA0A0_0003 : 32'hB0B0_0004;
                chk("cont_write", {31'd0, write}, 32'd1);
                chk("cont_windex", {27'd0, write_index}, exp_idx);
                chk("cont_wdata", write_data, exp_data);
                if ((k % 2) == 0) begin
                    chk("cont_ready0", {31'd0, req0_ready}, 32'd1);
                end else begin
                    chk("cont_ready1", {31'd0, req1_ready}, 32'd1);
                end
            end else begin
                chk("cont_first_write", {31'd0, write}, 32'd0);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("cont_drain_write", {31'd0, write}, 32'd0);
        chk("cont_drain_ready0", {31'd0, req0_ready}, 32'd1);
        chk("cont_drain_ready1", {31'd0, req1_ready}, 32'd1);

        // ---- zero index on req1 ----
        reserve_rule(5'd6);
        reserve       = 1'b1;
        reserve_index = 5'd6;
        tick();
        reserve    = 1'b0;
        req1_valid = 1'b1;
        req1_index = 5'd0;
        req1_data  = 32'h0000_1234;
        tick();
        req1_valid = 1'b0;
        #1;
        chk("z_ready1_busy", {31'd0, req1_ready}, 32'd0);
        chk("z_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("z_write", {31'd0, write}, 32'd0);
        chk("z_ready1_back", {31'd0, req1_ready}, 32'd1);
        chk("z_pending", pending, 32'h0000_0040);
        chk("z_stall_after", {31'd0, stall}, 32'd0);

        // ---- reserve/clear collision on r7 ----
        reserve_rule(5'd7);
        reserve       = 1'b1;
        reserve_index = 5'd7;
        tick();
        reserve = 1'b0;
        #1;
        chk("col_pend_set", pending, 32'h0000_00C0);
        req0_valid = 1'b1;
        req0_index = 5'd7;
        req0_data  = 32'h0000_0077;
        tick();
        req0_valid = 1'b0;
        // Re-reserve r7 on the very edge its write issues; the clear is
        // overridden so the bit is not stale afterwards.
        reserve       = 1'b1;
        reserve_index = 5'd7;
        tick();
        reserve = 1'b0;
        #1;
        chk("col_write", {31'd0, write}, 32'd1);
        chk("col_windex", {27'd0, write_index}, 32'd7);
        chk("col_pending", pending, 32'h0000_00C0);
        tick();
        chk("col_pending_hold", pending, 32'h0000_00C0);

        // ---- forwarding window on r9 ----
        read_index1 = 5'd9;
        req0_valid  = 1'b1;
        req0_index  = 5'd9;
        req0_data   = 32'h1001_0000;
        tick();
        req0_valid = 1'b0;
        reserve_rule(5'd9);
        reserve       = 1'b1;
        reserve_index = 5'd9;
        #1;
        chk("fwd_stall_pre", {31'd0, stall}, 32'd0);
        tick();
        reserve = 1'b0;
        #1;
        chk("fwd_write", {31'd0, write}, 32'd1);
        chk("fwd_windex", {27'd0, write_index}, 32'd9);
        chk("fwd_pending", pending, 32'h0000_02C0);
`ifdef RF_FWD_EN
        chk("fwd1_valid", {31'd0, fwd1_valid}, 32'd1);
        chk("fwd1_data", fwd1_data, 32'h1001_0000);
        chk("fwd2_valid", {31'd0, fwd2_valid}, 32'd0);
        chk("fwd_stall", {31'd0, stall}, 32'd0);
`else
        chk("nofwd_stall", {31'd0, stall}, 32'd1);
`endif
        tick();
        chk("fwd_after_write", {31'd0, write}, 32'd0);
        chk("fwd_after_stall", {31'd0, stall}, 32'd1);

        // ---- reset while a slot is held ----
        req0_valid = 1'b1;
        req0_index = 5'd11;
        req0_data  = 32'h0000_000B;
        tick();
        req0_valid = 1'b0;
        clear_n    = 1'b0;
        tick();
        chk("mrst_write", {31'd0, write}, 32'd0);
        chk("mrst_ready0", {31'd0, req0_ready}, 32'd1);
        chk("mrst_pending", pending, 32'd0);
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        clear_n = 1'b1;
        tick();
        chk("mrst_no_write", {31'd0, write}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 is ALU writeback and req1 is load writeback.
- Tracks outstanding destination registers in a scoreboard and raises a read-hazard stall toward decode.
- Drives write, write_index and write_data to the register file from flops. The register file samples on the falling clock edge, so its inputs are stable half a cycle after the rising edge.

Parameters:
- DATA_W, 32, register width
- IDX_W, 5, register index width
- NUM_REGS, 32, number of registers (2**IDX_W)

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- clear_n  in  1  synchronous active-low reset, sampled on the rising edge of clock
- req0_valid  in  1  ALU writeback request
- req0_ready  out  1  req0 slot empty
- req0_index  in  IDX_W  ALU destination register
- req0_data  in  DATA_W  ALU result
- req1_valid, req1_ready, req1_index, req1_data  same as req0, for load writeback
- reserve  in  1  decode issues an instruction with a destination register
- reserve_index  in  IDX_W  destination register being reserved
- read_index1  in  IDX_W  decode source register 1
- read_index2  in  IDX_W  decode source register 2
- stall  out  1  a source register is pending
- pending  out  NUM_REGS  scoreboard vector
- write  out  1  register file write enable
- write_index  out  IDX_W  register file write index
- write_data  out  DATA_W  register file write data

Behaviour:
- Reset (clear_n low at a rising edge) clears both slots, the pending vector, the output flops and the round-robin pointer. The pointer resets to favour req0.
- After reset: write=0, write_index=0, write_data=0, pending=0, req0_ready=1, req1_ready=1, stall=0.
- Reset asserted mid-operation discards any held slot contents and pending bits without issuing a write.
- Each requester has a 1-entry slot. readyN = slot N empty.
- A transfer occurs at a rising edge when validN and readyN are both high. The slot captures the index and data.
- Arbitration runs every cycle over the occupied slots:
  - One occupied slot wins.
  - Two occupied slots: the pointer decides the winner, then the pointer flips to the other requester.
- The winner is loaded into write/write_index/write_data at the rising edge, and its slot empties in the same edge.
- Latency: request accepted at edge T, slot present during T..T+1, write flop asserted from T+1 when uncontested, register file written at the falling edge of cycle T+1. Worst case is one extra cycle when the other slot wins.
- Throughput is one write per cycle.
- A slot freed at an edge shows readyN=1 in the next cycle. The slot cannot be emptied and refilled in the same cycle; a pass-through path is not allowed.
- Write to index 0: the slot is consumed and arbitrated normally, but write stays 0 for that cycle. Register 0 is never written.
- Scoreboard:
  - reserve with reserve_index != 0 sets pending[reserve_index] at the edge. Reserve of index 0 is ignored.
  - Issuing a write (write flop loaded with a nonzero index) clears pending[index] at that edge.
  - Reserve and clear of the same index at the same edge leaves the bit set (reserve wins).
- stall (combinational) = (read_index1 != 0 and pending[read_index1]) or (read_index2 != 0 and pending[read_index2]).
- Both slots holding the same index: writes go to the register file in arbitration order, and the last one issued stays in the register file. The pending bit clears on the first of the two writes.
- The arbiter has no request-order tracking; decode must not reserve an index that is already pending. The bench asserts this rule.

Optional Feature:
- Macro: RF_FWD_EN.
- When defined, adds these outputs:
  - fwd1_valid (1 bit): high when write=1 and write_index == read_index1 != 0.
  - fwd1_data (DATA_W): equals write_data.
  - fwd2_valid / fwd2_data: same, for read_index2.
- When defined, stall also ignores a source whose fwdN_valid is high.
- When undefined, these ports are absent and stall follows the base rule only.

Decomposition:
- Shared package rf_pkg: DATA_W, IDX_W, NUM_REGS constants; a zero-register constant; the request struct type rf_wreq_t {index, data}.
- One sub-module: rf_scoreboard. It holds the pending vector, set/clear priority and the stall compare, and is instantiated once.

Test Plan:
- Reset check: hold clear_n=0 for 2 cycles with both reqs valid. Required: req*_ready=1, write=0, pending=0; release reset, and no write occurs before the first accept.
- Single write: reserve 5, then req0 index 5 data 0xDEADBEEF. Required: write=1 index 5 one cycle after accept; pending[5]=1 until that edge, 0 after; stall for read_index1=5 drops on the same edge.
- Contention: both reqs valid every cycle, req0 idx 3 / req1 idx 4, for 4 accepts each. Required: issued indices alternate 3,4,3,4…; each ready returns 1 one cycle after its slot wins.
- Zero index: req1 index 0 data 0x1234. Required: slot consumed, write stays 0, pending unchanged; read_index2=0 never stalls.
- Reserve/clear collision: pending[7]=1, write for idx 7 issues in the same cycle as reserve 7. Required: pending[7] stays 1.
- Forwarding (RF_FWD_EN): read_index1=9 while write of idx 9 data 0x10010000 is asserted. Required: fwd1_valid=1, fwd1_data=0x10010000, stall=0. With the macro undefined: stall=1 in that cycle.
